// File: rtl/div_pkg.sv
// div_pkg: shared widths and FSM encoding for the sequential divider.
//   DIV_WIDTH  default operand width
//   DIV_SLICES number of 8-bit borrow slices in the trial subtractor
//   state_t    divider FSM states
package div_pkg;
    localparam int DIV_WIDTH  = 32;
    localparam int DIV_SLICES = DIV_WIDTH / 8;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
endpackage

// File: rtl/sub_8bit_borrow_yjy.sv
// sub_8bit_borrow_yjy: 8-bit subtract slice with borrow in/out.
//   a, b  minuend and subtrahend
//   bi    borrow in from the lower slice
//   diff  a - b - bi (mod 256)
//   bo    borrow out to the next slice
module sub_8bit_borrow_yjy #(
    parameter int UUID = 0
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bi,
    output logic [7:0] diff,
    output logic       bo
);
    assign {bo, diff} = {1'b0, a} - {1'b0, b} - {8'd0, bi};
endmodule

// File: rtl/div32_seq_yjy.sv
// div32_seq_yjy: sequential restoring unsigned divider, one quotient bit per clock.
//   clk, rst (sync, active low)
//   start, dividend, divisor    request, operands sampled on the accepting edge
//   busy, done, div_by_zero     status; done is a one-cycle result-valid pulse
//   quotient, remainder         results, held until the next accept
module div32_seq_yjy
    import div_pkg::*;
#(
    parameter int    UUID  = 0,
    parameter string NAME  = "",
    parameter int    WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int SLICES = WIDTH / 8;
    localparam int CW     = $clog2(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] dq, d, rem, r_lo, diff;
    logic [CW-1:0]    cnt;
    logic [SLICES:0]  bc;
    logic             accept, take, busy_n, done_n;

    assign accept = start && !busy && state == S_IDLE;
    assign r_lo   = {rem[WIDTH-2:0], dq[WIDTH-1]};
    assign bc[0]  = 1'b0;

    for (genvar i = 0; i < SLICES; i++) begin : g_slice
        sub_8bit_borrow_yjy #(.UUID(UUID ^ i)) u_sub (
            .a    (r_lo[8*i +: 8]),
            .b    (d[8*i +: 8]),
            .bi   (bc[i]),
            .diff (diff[8*i +: 8]),
            .bo   (bc[i+1])
        );
    end

    // The bit shifted out of rem is the 33rd bit of the partial remainder;
    // when set, the partial remainder already exceeds any WIDTH-bit divisor.
    assign take = rem[WIDTH-1] | ~bc[SLICES];

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state == S_IDLE ? (accept ? (divisor == '0 ? S_DONE : S_RUN) : S_IDLE)
                : state == S_RUN  ? (cnt == '0 ? S_DONE : S_RUN)
                :                   S_IDLE;
    end

    always_comb begin
        busy_n = state != S_IDLE;
        done_n = state == S_DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            dq          <= '0;
            d           <= '0;
            rem         <= '0;
            cnt         <= '0;
        end else begin
            busy <= busy_n;
            done <= done_n;
            if (accept) begin
                dq  <= dividend;
                d   <= divisor;
                rem <= '0;
                cnt <= CW'(WIDTH - 1);
            end
            if (state == S_RUN) begin
                rem <= take ? diff : r_lo;
                dq  <= {dq[WIDTH-2:0], take};
                cnt <= cnt - CW'(1);
            end
            if (state == S_DONE) begin
                div_by_zero <= d == '0;
                quotient    <= d == '0 ? '1 : dq;
                remainder   <= d == '0 ? dq : rem;
            end
        end
    end
endmodule

// File: tb/tb_div32_seq_yjy.sv
// tb_div32_seq_yjy: scoreboard bench for the sequential divider.
module tb_div32_seq_yjy;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [31:0] dividend = '0, divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0;

    div32_seq_yjy #(.UUID(0), .NAME("dut"), .WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // first idle cycle after the done pulse. inj >= 0 pulses start with
    // (ia, ib) at that cycle offset after accept.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input int inj, input logic [31:0] ia, input logic [31:0] ib);
        exp_t e, x;
        int   lat, bc, exp_lat;
        bit   got;
        e.z = b == 0;
        e.q = e.z ? 32'hFFFF_FFFF : a / b;
        e.r = e.z ? a : a % b;
        sb.push_back(e);
        exp_lat = e.z ? 1 : 33;
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        lat = 0; bc = 0; got = 0;
        while (!got && lat < 100) begin
            if (busy) bc++;
            if (done) got = 1;
            else begin
                if (lat == inj) begin dividend = ia; divisor = ib; start = 1'b1; end
                else start = 1'b0;
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        x = sb.size() > 0 ? sb.pop_front() : '0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout a=%h b=%h got no done within %0d cycles", a, b, lat);
        end else begin
            checks += 6;
            if (lat !== exp_lat) begin failures++; $display("FAIL latency a=%h b=%h got %0d exp %0d", a, b, lat, exp_lat); end
            if (bc !== exp_lat) begin failures++; $display("FAIL busy_cycles a=%h b=%h got %0d exp %0d", a, b, bc, exp_lat); end
            if (quotient !== x.q) begin failures++; $display("FAIL quotient a=%h b=%h got %h exp %h", a, b, quotient, x.q); end
            if (remainder !== x.r) begin failures++; $display("FAIL remainder a=%h b=%h got %h exp %h", a, b, remainder, x.r); end
            if (div_by_zero !== x.z) begin failures++; $display("FAIL dbz a=%h b=%h got %b exp %b", a, b, div_by_zero, x.z); end
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL after_done a=%h b=%h got done=%b busy=%b exp 0 0", a, b, done, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; dividend = 100; divisor = 7;
        @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 0 || remainder !== 0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b dbz=%b q=%h r=%h exp all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_overrides_start got busy=%b exp 0", busy); end
    endtask

    task automatic test_basic();
        do_op(32'd100, 32'd7, -1, 0, 0);
        do_op(32'hFFFF_FFFF, 32'h8000_0001, -1, 0, 0);
        do_op(32'h1234_5678, 32'd0, -1, 0, 0);
    endtask

    task automatic test_back_to_back();
        do_op(32'd5, 32'd9, -1, 0, 0);
        do_op(32'd9, 32'd9, -1, 0, 0);
    endtask

    task automatic test_start_while_busy();
        int pulses = 0;
        do_op(32'd1000, 32'd3, 5, 32'd1, 32'd1);
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin failures++; $display("FAIL extra_done got %0d pulses exp 0", pulses); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        dividend = 77; divisor = 5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 0 || remainder !== 0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b done=%b q=%h r=%h exp 0 0 0 0", busy, done, quotient, remainder);
        end
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin failures++; $display("FAIL aborted_done got %0d pulses exp 0", pulses); end
        do_op(32'd77, 32'd5, -1, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] corners [6];
        logic [31:0] a, b;
        corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
        for (int i = 0; i < 250; i++) begin
            a = $urandom_range(0, 3) == 0 ? corners[$urandom_range(0, 5)] : $urandom;
            b = $urandom_range(0, 3) == 0 ? corners[$urandom_range(0, 5)] : ($urandom >> $urandom_range(0, 31));
            do_op(a, b, -1, 0, 0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_left got %0d exp 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
